// File: rtl/spectrum_bin_streamer_if.sv
// rtl/spectrum_bin_streamer_if.sv - request, BRAM read and bin stream signals of the spectrum bin streamer
// The master side is the streamer; the slave side is the requester, BRAM and peak finder.
interface spectrum_bin_streamer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
);
   logic              go;
   logic [ADDR_W-1:0] first_bin;
   logic [ADDR_W-1:0] last_bin;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              start;
   logic [DATA_W-1:0] data_out;
   logic [ADDR_W-1:0] index;
   logic              valid;
   logic              busy;
   logic              done;

   modport master (
      input  go, first_bin, last_bin, rd_data,
      output rd_addr, start, data_out, index, valid, busy, done
   );

   modport slave (
      output go, first_bin, last_bin, rd_data,
      input  rd_addr, start, data_out, index, valid, busy, done
   );
endinterface

// File: rtl/spectrum_bin_streamer.sv
// rtl/spectrum_bin_streamer.sv - streams a BRAM bin range [first_bin..last_bin] to a peak finder
// One FILL cycle covers the BRAM read latency; the range end is found by equality, never by overflow.
module spectrum_bin_streamer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input logic                   clk,
   input logic                   reset,
   spectrum_bin_streamer_if.master bus
);
   typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W-1:0] index_q;
   logic [ADDR_W-1:0] last_q;
   logic              start_q;
   logic              range_ok;

   assign range_ok = (bus.first_bin <= bus.last_bin);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.go) state_nxt = range_ok ? FILL : DONE;
         FILL:    state_nxt = STREAM;
         STREAM:  if (index_q == last_q) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // rd_addr runs one bin ahead of index so rd_data lines up with the bin on index.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr_q <= '0;
         index_q   <= '0;
         last_q    <= '0;
         start_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               start_q <= 1'b0;
               if (bus.go && range_ok) begin
                  rd_addr_q <= bus.first_bin;
                  last_q    <= bus.last_bin;
               end
            end
            FILL: begin
               index_q <= rd_addr_q;
               start_q <= 1'b1;
               if (rd_addr_q != last_q) rd_addr_q <= rd_addr_q + 1'b1;
            end
            STREAM: begin
               start_q <= 1'b0;
               if (index_q != last_q) index_q <= index_q + 1'b1;
               if (rd_addr_q != last_q) rd_addr_q <= rd_addr_q + 1'b1;
            end
            default: start_q <= 1'b0;
         endcase
      end
   end

   assign bus.rd_addr  = rd_addr_q;
   assign bus.valid    = (state == STREAM);
   assign bus.start    = start_q;
   assign bus.index    = index_q;
   assign bus.data_out = bus.valid ? bus.rd_data : '0;
   assign bus.busy     = (state != IDLE);
   assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_spectrum_bin_streamer.sv
// tb/tb_spectrum_bin_streamer.sv - randomized bench for spectrum_bin_streamer against a per-cycle range model
module tb_spectrum_bin_streamer;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail = 0;
   int   exp_index = 0;
   logic [31:0] mem [512];

   always #5 clk = ~clk;

   spectrum_bin_streamer_if #(.DATA_W(32), .ADDR_W(9)) bus ();

   spectrum_bin_streamer #(.DATA_W(32), .ADDR_W(9)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, " busy"}, 32'(bus.busy), 0);
      check_eq({tag, " done"}, 32'(bus.done), 0);
      check_eq({tag, " valid"}, 32'(bus.valid), 0);
      check_eq({tag, " start"}, 32'(bus.start), 0);
      check_eq({tag, " data"}, bus.data_out, 0);
      check_eq({tag, " index"}, 32'(bus.index), 0);
      check_eq({tag, " rd_addr"}, 32'(bus.rd_addr), 0);
   endtask

   // Called at a negedge while the DUT is idle; go is taken at the next rising edge (T).
   task automatic run_range(input int first, input int last, input bit repulse);
      int  n;
      int  n_cyc;
      bit  ok;
      bit  e_valid;
      bit  e_start;
      bit  e_done;
      bit  e_busy;
      ok    = (first <= last);
      n     = ok ? (last - first + 1) : 0;
      n_cyc = ok ? n + 3 : 2;
      bus.go        = 1'b1;
      bus.first_bin = 9'(first);
      bus.last_bin  = 9'(last);
      for (int k = 1; k <= n_cyc; k++) begin
         @(negedge clk);
         bus.go        = repulse && (k < n_cyc) && ($urandom_range(0, 2) == 0);
         bus.first_bin = 9'($urandom_range(0, 511));
         bus.last_bin  = 9'($urandom_range(0, 511));
         if (ok) begin
            e_valid = (k >= 2) && (k <= n + 1);
            e_start = (k == 2);
            e_done  = (k == n + 2);
            e_busy  = (k <= n + 2);
            if (e_valid) exp_index = first + k - 2;
            if (k <= n) check_eq("rd_addr", 32'(bus.rd_addr), 32'(first + k - 1));
         end else begin
            e_valid = 1'b0;
            e_start = 1'b0;
            e_done  = (k == 1);
            e_busy  = (k == 1);
         end
         check_eq("valid", 32'(bus.valid), 32'(e_valid));
         check_eq("start", 32'(bus.start), 32'(e_start));
         check_eq("done", 32'(bus.done), 32'(e_done));
         check_eq("busy", 32'(bus.busy), 32'(e_busy));
         check_eq("index", 32'(bus.index), 32'(exp_index));
         check_eq("data", bus.data_out, e_valid ? mem[exp_index] : 32'd0);
      end
      bus.go = 1'b0;
   endtask

   initial begin
      int f;
      int l;
      for (int i = 0; i < 512; i++) mem[i] = 32'(i * 3);
      mem[10] = 32'hDEADBEEF;
      reset         = 1'b1;
      bus.go        = 1'b1;
      bus.first_bin = 9'd0;
      bus.last_bin  = 9'd5;
      repeat (3) begin
         @(negedge clk);
         check_quiet("reset");
      end
      reset = 1'b0;
      run_range(4, 7, 1'b0);
      run_range(10, 10, 1'b0);
      run_range(508, 511, 1'b1);
      run_range(9, 3, 1'b0);
      run_range(9, 3, 1'b1);

      // Abort a full-range stream with reset in cycle T+4.
      bus.go        = 1'b1;
      bus.first_bin = 9'd0;
      bus.last_bin  = 9'd511;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.go = 1'b0;
         check_eq("abort valid", 32'(bus.valid), 32'(k >= 2));
         if (k >= 2) check_eq("abort index", 32'(bus.index), 32'(k - 2));
      end
      reset = 1'b1;
      @(negedge clk);
      check_quiet("abort");
      reset     = 1'b0;
      exp_index = 0;
      run_range(0, 1, 1'b0);

      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      for (int r = 0; r < 40; r++) begin
         f = $urandom_range(0, 511);
         case ($urandom_range(0, 3))
            0:       l = $urandom_range(0, 511);
            1:       l = 511;
            default: l = (f + $urandom_range(0, 24) > 511) ? 511 : f + $urandom_range(0, 24);
         endcase
         run_range(f, l, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule

// File: doc/spectrum_bin_streamer.md
SPECTRUM_BIN_STREAMER -- requirements
Module: spectrum_bin_streamer

Interface
REQ-001: Parameter DATA_W, default 32, width of a spectrum bin magnitude word.
REQ-002: Parameter ADDR_W, default 9, bin address/index width (512 bins).
REQ-003: clk  input  1  sole clock; all logic on rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: go  input  1  single-cycle request to stream one bin range.
REQ-006: first_bin  input  ADDR_W  first bin address of range, sampled with go.
REQ-007: last_bin  input  ADDR_W  last bin address of range (inclusive), sampled with go.
REQ-008: rd_addr  output  ADDR_W  registered read address to spectrum BRAM.
REQ-009: rd_data  input  DATA_W  BRAM read data, valid the cycle after rd_addr is presented.
REQ-010: start  output  1  high only on the cycle carrying the first bin of a stream.
REQ-011: data_out  output  DATA_W  bin magnitude for the downstream peak finder.
REQ-012: index  output  ADDR_W  bin address of the word currently on data_out.
REQ-013: valid  output  1  high on every cycle data_out/index carry a bin.
REQ-014: busy  output  1  high from the cycle after an accepted go through the done cycle, inclusive.
REQ-015: done  output  1  single-cycle pulse marking peak result ready downstream.

Function
REQ-016: The block SHALL implement states IDLE, FILL, STREAM, DONE; only IDLE accepts go.
REQ-017: go accepted (edge T) with first_bin <= last_bin SHALL latch both bounds, drive rd_addr=first_bin and enter FILL in cycle T+1.
REQ-018: FILL SHALL last exactly one cycle and then enter STREAM; start, valid=1, index=first_bin, data_out=mem[first_bin] in cycle T+2.
REQ-019: For N = last_bin-first_bin+1 bins, valid SHALL be high on consecutive cycles T+2..T+1+N, with index ascending by 1 and data_out=mem[index] each cycle, no gaps.
REQ-020: start SHALL be high only in cycle T+2; if N=1, start and the sole valid cycle coincide.
REQ-021: DONE SHALL occupy cycle T+2+N only (one cycle after the last valid, so the peak finder's registered result is settled); done=1, busy=1, then IDLE.
REQ-022: data_out SHALL be forced to 0 whenever valid=0, so the always-comparing downstream peak finder never captures stale BRAM data.
REQ-023: index SHALL hold its last value when valid=0; rd_addr SHALL hold its last value in IDLE/DONE.
REQ-024: Address progression SHALL terminate by equality compare with last_bin, not by counter overflow; last_bin=2^ADDR_W-1 SHALL stream correctly with no wrap to bin 0.
REQ-025: go with first_bin > last_bin SHALL emit no start/valid, and SHALL pulse done (busy=1) in cycle T+1, then IDLE.
REQ-026: go while busy (FILL, STREAM, DONE) SHALL be ignored with no effect on the stream in progress.
REQ-027: first_bin/last_bin changes after the accepting edge SHALL not affect the stream in progress.

Reset
REQ-028: reset high at an edge SHALL force IDLE and start=0, valid=0, busy=0, done=0, data_out=0, index=0, rd_addr=0 in the following cycle.
REQ-029: reset SHALL override go on the same edge; reset mid-stream SHALL abort without pulsing done.
REQ-030: go SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-031: mem[k]=k*3, go with first=4,last=7 -> T+2..T+5 index 4,5,6,7, data 12,15,18,21; start only T+2; done only T+6; data_out=0 from T+6.
REQ-032: first=last=10, mem[10]=0xDEADBEEF -> start=valid=1 one cycle (T+2), data 0xDEADBEEF; done T+3.
REQ-033: first=508,last=511 -> indices 508..511 then done; rd_addr never returns to 0 during stream.
REQ-034: first=9,last=3 -> no valid/start, done at T+1, busy high T+1 only.
REQ-035: reset asserted in cycle T+4 of a 0..511 stream -> all outputs 0 next cycle, no done; new go with first=0,last=1 then streams normally.
REQ-036: go re-pulsed during STREAM and in the DONE cycle -> ignored; go one cycle after done accepted.
